// File: rtl/riscv_uart_tx.sv
// riscv_uart_tx: memory-mapped 8N1 UART transmitter with a byte FIFO.
// The io bridge pushes bytes at store time. The FSM pops them one at a time
// and shifts each one out LSB first. All status outputs come from registers.
module riscv_uart_tx #(
  parameter int CLK_FREQ_HZ = 23000000,
  parameter int BAUD        = 128000,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  input  logic                          clr_ovf,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          tx_busy,
  output logic                          ovf,
  output logic                          tx
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PTR_W        = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] BAUD_ONE  = CNT_W'(1);
  localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [2:0]       next_idx;
  logic [7:0]       sh;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic push;
  logic pop;
  logic drop;
  logic baud_last;

  // Full and empty are decoded from the registered count, so they change
  // one cycle after the edge that caused them.
  assign fifo_full  = (fifo_count == DEPTH_CNT);
  assign fifo_empty = (fifo_count == '0);

  // A write that arrives while the FIFO is full is dropped. This holds even
  // when a pop happens on the same edge.
  assign push      = wr_en && !fifo_full;
  assign drop      = wr_en && fifo_full;
  assign pop       = (state == IDLE) && !fifo_empty;
  assign baud_last = (baud_cnt == BAUD_LAST);
  assign next_idx  = bit_idx + 3'd1;

  // Byte storage: written on push and read by the FSM when it pops.
  // NOTE: the storage array has no reset. Only the pointers and the count
  // define which entries are valid, so resetting the array would only add
  // reset fan-out.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // FIFO pointers, occupancy count and the sticky overflow flag.
  // NOTE: every register is updated with non-blocking assignments. Each
  // block then sees the values from before the edge, which is what the
  // push/pop/full decisions rely on.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      ovf        <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_ONE;
        2'b01:   fifo_count <= fifo_count - CNT_ONE;
        default: fifo_count <= fifo_count;
      endcase
      // Setting the flag takes priority over clearing it, so a drop that
      // coincides with clr_ovf is never lost.
      if (drop)         ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
    end
  end

  // Frame FSM: START, then eight DATA bits LSB first, then STOP. Each bit is
  // held for CLKS_PER_BIT cycles. tx and tx_busy are registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      sh       <= '0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            sh       <= mem[rd_ptr];
            baud_cnt <= '0;
            state    <= START;
            tx       <= 1'b0;
            tx_busy  <= 1'b1;
          end
        end
        START: begin
          if (baud_last) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
            tx       <= sh[0];
          end else begin
            baud_cnt <= baud_cnt + BAUD_ONE;
          end
        end
        DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= next_idx;
              tx      <= sh[next_idx];
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_ONE;
          end
        end
        STOP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            state    <= IDLE;
            tx_busy  <= 1'b0;
          end else begin
            baud_cnt <= baud_cnt + BAUD_ONE;
          end
        end
        default: begin
          state   <= IDLE;
          tx      <= 1'b1;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
